// File: rtl/div_iter_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_iter_unit_pkg
// Shared definitions for the iterative EX-stage divider.
//   div_state_t : divider FSM state encoding (IDLE / BUSY / DONE)
//   DIV_WIDTH   : default operand/result width
//   DIV_CNT_W   : default iteration counter width (2**DIV_CNT_W > DIV_WIDTH)
// -----------------------------------------------------------------------------
package div_iter_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_iter_unit_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
// Combinational conditional two's-complement negation of two values.
// Used once to take absolute values of the operands and once to apply the
// quotient/remainder signs to the unsigned iteration result.
//   a_val/a_neg : first value and its negate request  -> a_res
//   b_val/b_neg : second value and its negate request -> b_res
// All arithmetic is modulo 2**WIDTH.
// -----------------------------------------------------------------------------
module div_sign_fix
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] a_val,
    input  logic             a_neg,
    input  logic [WIDTH-1:0] b_val,
    input  logic             b_neg,
    output logic [WIDTH-1:0] a_res,
    output logic [WIDTH-1:0] b_res
);

    assign a_res = a_neg ? -a_val : a_val;
    assign b_res = b_neg ? -b_val : b_val;

endmodule

// File: rtl/div_iter_unit.sv
// -----------------------------------------------------------------------------
// div_iter_unit
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Quotient goes to lo_out, remainder to hi_out.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   div_en       : valid DIV/DIVU in EX
//   div_signed   : 1 = DIV, 0 = DIVU (sampled at accept)
//   opa, opb     : dividend / divisor (sampled at accept)
//   flushE       : EX flush, cancels any operation
//   stall_other  : cache stall; EX cannot advance while high
//   div_stall    : stall request to the hazard unit
//   div_ready    : result valid this cycle (state DONE)
//   lo_out       : quotient
//   hi_out       : remainder
//
// Handshake: the EX instruction presents div_en and is held by div_stall until
// the unit reaches DONE. DONE is left only when the pipeline actually advances
// (stall_other low), so a result held by a cache stall is never recomputed.
// -----------------------------------------------------------------------------
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_en,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flushE,
    input  logic             stall_other,
    output logic             div_stall,
    output logic             div_ready,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;

    // quo_q starts as |dividend| and is shifted out MSB-first while quotient
    // bits are shifted in at the LSB.
    logic [WIDTH-1:0] quo_q, rem_q, dsr_q, opa_raw_q;
    logic             q_sign_q, r_sign_q, dz_q;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] quo_step, rem_step, fix_q, fix_r;
    logic             accept, step, last_step, load_result;

    div_sign_fix #(.WIDTH(WIDTH)) u_in_fix (
        .a_val (opa),
        .a_neg (div_signed & opa[WIDTH-1]),
        .b_val (opb),
        .b_neg (div_signed & opb[WIDTH-1]),
        .a_res (abs_a),
        .b_res (abs_b)
    );

    // Fixup works on this cycle's step result so the final value can be
    // registered in the same edge that enters DONE.
    div_sign_fix #(.WIDTH(WIDTH)) u_out_fix (
        .a_val (quo_step),
        .a_neg (q_sign_q),
        .b_val (rem_step),
        .b_neg (r_sign_q),
        .a_res (fix_q),
        .b_res (fix_r)
    );

    // Partial remainder is always below the divisor, so WIDTH+1 bits hold the
    // shifted value and the borrow of the trial subtraction.
    assign shifted   = {rem_q, quo_q[WIDTH-1]};
    assign trial     = shifted - {1'b0, dsr_q};
    assign quo_step  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    assign rem_step  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        step        = 1'b0;
        load_result = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (div_en && !flushE) begin
                    accept    = 1'b1;
                    state_nxt = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                // Losing div_en mid-operation means the instruction left EX.
                if (flushE || !div_en) begin
                    state_nxt = DIV_IDLE;
                end else begin
                    step = 1'b1;
                    if (last_step) begin
                        load_result = 1'b1;
                        state_nxt   = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                if (flushE || !stall_other) begin
                    state_nxt = DIV_IDLE;
                end
            end
            default: state_nxt = DIV_IDLE;
        endcase
    end

    assign div_stall = div_en & ~flushE & (state != DIV_DONE);
    assign div_ready = (state == DIV_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DIV_IDLE;
            cnt       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            opa_raw_q <= '0;
            q_sign_q  <= 1'b0;
            r_sign_q  <= 1'b0;
            dz_q      <= 1'b0;
            lo_out    <= '0;
            hi_out    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                quo_q     <= abs_a;
                dsr_q     <= abs_b;
                rem_q     <= '0;
                opa_raw_q <= opa;
                q_sign_q  <= div_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                r_sign_q  <= div_signed & opa[WIDTH-1];
                dz_q      <= (opb == '0);
                cnt       <= '0;
            end
            if (step) begin
                quo_q <= quo_step;
                rem_q <= rem_step;
                cnt   <= cnt + CNT_W'(1);
            end
            if (load_result) begin
                // Divide by zero reports the raw dividend, without sign fixup.
                lo_out <= dz_q ? '1 : fix_q;
                hi_out <= dz_q ? opa_raw_q : fix_r;
            end
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_div_iter_unit
// Directed and randomized stimulus for div_iter_unit with an expected-result
// queue; inputs are driven 1 time unit after the rising edge and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_div_iter_unit;

    localparam int W = 32;
    localparam int LAT_STALL = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         div_en;
    logic         div_signed;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         flushE;
    logic         stall_other;
    logic         div_stall;
    logic         div_ready;
    logic [W-1:0] lo_out;
    logic [W-1:0] hi_out;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    div_iter_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .div_en      (div_en),
        .div_signed  (div_signed),
        .opa         (opa),
        .opb         (opb),
        .flushE      (flushE),
        .stall_other (stall_other),
        .div_stall   (div_stall),
        .div_ready   (div_ready),
        .lo_out      (lo_out),
        .hi_out      (hi_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: SystemVerilog signed division truncates toward zero and the
    // remainder takes the dividend's sign, matching DIV semantics.
    function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi);
        div_en     = 1'b1;
        div_signed = sgn;
        opa        = a;
        opb        = b;
        exp_q.push_back({ehi, elo});
    endtask

    // Starts at a drive point; returns at the falling edge of the first DONE cycle.
    task automatic wait_result(output int stalls, output bit got);
        stalls = 0;
        got    = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (div_ready) begin
                got = 1'b1;
                break;
            end
            if (div_stall) stalls++;
            tick();
        end
    endtask

    task automatic compare_result(input string tag, input int stalls, input bit got);
        logic [2*W-1:0] e;
        check({tag, "_done"}, 64'(got), 64'(1));
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'(1));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check({tag, "_lo"}, 64'(lo_out), 64'(e[W-1:0]));
        check({tag, "_hi"}, 64'(hi_out), 64'(e[2*W-1:W]));
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(LAT_STALL));
        check({tag, "_stall_in_done"}, 64'(div_stall), 64'(0));
    endtask

    task automatic finish_op(input string tag);
        tick();
        div_en = 1'b0;
        @(negedge clk);
        check({tag, "_ready_cleared"}, 64'(div_ready), 64'(0));
        tick();
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] elo,
                           input logic [W-1:0] ehi);
        int stalls;
        bit got;
        issue(sgn, a, b, elo, ehi);
        wait_result(stalls, got);
        compare_result(tag, stalls, got);
        finish_op(tag);
    endtask

    initial begin
        int stalls;
        bit got;
        logic [2*W-1:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rs;

        rst = 1'b1; div_en = 1'b0; div_signed = 1'b0; opa = '0; opb = '0;
        flushE = 1'b0; stall_other = 1'b0;
        #12;
        check("rst_stall", 64'(div_stall), 64'(0));
        check("rst_ready", 64'(div_ready), 64'(0));
        check("rst_lo", 64'(lo_out), 64'(0));
        check("rst_hi", 64'(hi_out), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("divu_by0", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
        run_div("div_by0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run_div("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);

        // Flush on the 10th BUSY cycle; nothing is expected from that operation.
        div_en = 1'b1; div_signed = 1'b0; opa = 32'd50; opb = 32'd5;
        for (int k = 0; k < 10; k++) tick();
        flushE = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(div_stall), 64'(0));
        tick();
        flushE = 1'b0;
        div_en = 1'b0;
        @(negedge clk);
        check("flush_ready", 64'(div_ready), 64'(0));
        tick();
        run_div("after_flush", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Cache stall held across BUSY and the first 5 DONE cycles.
        stall_other = 1'b1;
        issue(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10);
        wait_result(stalls, got);
        compare_result("hold", stalls, got);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("hold_ready", 64'(div_ready), 64'(1));
            check("hold_lo", 64'(lo_out), 64'(30));
            check("hold_hi", 64'(hi_out), 64'(10));
            check("hold_stall", 64'(div_stall), 64'(0));
        end
        tick();
        stall_other = 1'b0;
        @(negedge clk);
        check("release_ready", 64'(div_ready), 64'(1));
        check("release_stall", 64'(div_stall), 64'(0));
        // The next DIV stays in EX: accepted only once the unit is back in IDLE.
        tick();
        issue(1'b0, 32'd77, 32'd7, 32'd11, 32'd0);
        wait_result(stalls, got);
        compare_result("next_div", stalls, got);
        finish_op("next_div");

        // Randomized operands against the reference model.
        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(1, 50));
            if (rs && ($urandom_range(0, 1) != 0)) rb = -rb;
            if (rb == '0) rb = 32'd1;
            if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            m = model(rs, ra, rb);
            run_div("rand", rs, ra, rb, m[W-1:0], m[2*W-1:W]);
        end

        // Asynchronous reset in the middle of a BUSY cycle.
        div_en = 1'b1; div_signed = 1'b0; opa = 32'd500; opb = 32'd3;
        for (int k = 0; k < 5; k++) tick();
        #3;
        rst = 1'b1;
        div_en = 1'b0;
        #1;
        check("arst_lo", 64'(lo_out), 64'(0));
        check("arst_hi", 64'(hi_out), 64'(0));
        check("arst_ready", 64'(div_ready), 64'(0));
        check("arst_stall", 64'(div_stall), 64'(0));
        #2;
        rst = 1'b0;
        tick();
        run_div("after_rst", 1'b0, 32'd500, 32'd3, 32'd166, 32'd2);

        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage; executes DIV/DIVU.
- Produces the ALU stall request consumed by the hazard unit, and obeys that unit's EX flush and the global cache stall.
- Writes quotient to LO and remainder to HI.
- Holds a finished result stable until the EX stage actually advances, so an instruction held by a cache stall is never re-executed.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- div_en  in  1  instruction in EX is DIV/DIVU and is valid.
- div_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled at accept.
- opa  in  WIDTH  dividend; sampled at accept.
- opb  in  WIDTH  divisor; sampled at accept.
- flushE  in  1  EX flush from the hazard unit; cancels any operation.
- stall_other  in  1  i/d cache stall (instruction/data cache stall, OR of the two); when high, EX cannot advance even if the divider is done.
- div_stall  out  1  stall request to the hazard unit (the alu_stallE source).
- div_ready  out  1  result valid this cycle.
- lo_out  out  WIDTH  quotient.
- hi_out  out  WIDTH  remainder.

Behaviour:
- Reset: state = IDLE, counter = 0, all internal registers = 0, div_stall = 0, div_ready = 0, lo_out = 0, hi_out = 0.
- States:
  - IDLE: accept when div_en & ~flushE. At accept:
    - latch |opa| and |opb| (absolute values taken only when div_signed = 1);
    - latch quotient sign = sign(opa) XOR sign(opb), remainder sign = sign(opa), and divide-by-zero flag (opb == 0);
    - clear the partial remainder; next state BUSY; counter = 0.
  - BUSY: one restoring step per cycle.
    - Shift the {remainder, dividend} pair left by 1.
    - Trial-subtract the divisor on WIDTH+1 bits.
    - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the quotient LSB to 0.
    - After WIDTH steps (counter == WIDTH-1), next state DONE, and the sign-corrected result is registered into lo_out/hi_out.
  - DONE: div_ready = 1; lo_out/hi_out held constant.
    - If stall_other = 1, stay in DONE.
    - If stall_other = 0, next state IDLE; this is the cycle in which EX advances.
- div_stall = div_en & ~flushE & (state != DONE). It is combinational, so it asserts in the accept cycle itself.
- Latency for an accept in cycle N:
  - BUSY during N+1 .. N+WIDTH;
  - DONE first at N+WIDTH+1, where div_stall = 0 and div_ready = 1;
  - total div_stall cycles = WIDTH+1 (33 at the default WIDTH).
- Sign fixup at result register:
  - lo_out = quotient sign ? -q : q;
  - hi_out = remainder sign ? -r : r;
  - all arithmetic modulo 2^WIDTH.
- Signed overflow 0x80000000 / -1 falls out naturally: lo_out = 0x80000000, hi_out = 0.
- Divide by zero (takes the full latency):
  - lo_out = all ones, hi_out = opa as latched (raw, no sign fixup);
  - applies to both signed and unsigned.
- flushE = 1 in any state:
  - next state IDLE;
  - div_stall = 0 in the same cycle;
  - div_ready forced 0 from the next cycle;
  - no accept happens in that cycle.
- stall_other during BUSY has no effect: iteration continues.
- div_en dropping during BUSY is treated as a cancel: next state IDLE.
- div_en = 1 in DONE with stall_other = 0: return to IDLE, with no new accept in that cycle. A following DIV in EX is accepted next cycle.
- rst asserted mid-operation: immediate return to the reset values, regardless of clk.
- lo_out/hi_out keep their last values in IDLE; consumers qualify them with div_ready.

Decomposition:
- Shared package/header: state encodings DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2; default WIDTH constant.
- One natural sub-module: div_sign_fix, combinational. It handles abs-on-input and conditional negate-on-output, and is instanced twice: input conditioning and result fixup.
- FSM, counter and iteration datapath stay in div_iter_unit.

Test Plan:
- DIVU 100/7, stall_other = 0:
  - div_stall high for exactly 33 cycles starting in the accept cycle;
  - then div_ready = 1, lo_out = 14, hi_out = 2.
- DIV -7/2 → lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF.
- DIV 7/-2 → lo_out = 0xFFFFFFFD, hi_out = 1.
- DIV 0x80000000 / 0xFFFFFFFF → lo_out = 0x80000000, hi_out = 0, no hang.
- DIVU 0x1234/0 → lo_out = 0xFFFFFFFF, hi_out = 0x1234, after 33 stall cycles.
- flushE pulsed on BUSY cycle 10:
  - div_stall = 0 in that cycle; IDLE next;
  - a new DIVU 9/3 issued 2 cycles later gives lo_out = 3, hi_out = 0 after a full 33 cycles.
- DONE reached with stall_other held for 5 cycles:
  - div_ready stays 1, lo_out/hi_out unchanged, div_stall = 0, no re-accept;
  - IDLE the cycle after stall_other falls.
- rst asserted mid-BUSY, between clock edges → all outputs 0 immediately.
